alu_serial_host: RTL and testbench

- Host-side driver for the bit-serial ALU.
- Accepts parallel (opcode, A, B) requests through a valid/ready handshake.
- Serializes each request into the ALU's continuous frame stream, and deserializes the ALU's reply stream back into a parallel result with status flags.
- Sits between the control logic and the serial ALU. Its ser_out drives the ALU Data_in; its ser_in is fed from the ALU Data_out.

---
 rtl/alu_serial_host_if.sv | 28 ++
 rtl/alu_serial_host.sv | 77 +++++++
 tb/tb_alu_serial_host.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_host_if.sv
// alu_serial_host_if: request, response and serial-link signals of alu_serial_host.
interface alu_serial_host_if #(
    parameter int N = 2
);
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_op;
    logic [N-1:0]   req_a;
    logic [N-1:0]   req_b;
    logic           ser_out;
    logic           ser_in;
    logic           resp_valid;
    logic [1:0]     resp_op;
    logic [2*N-1:0] resp_result;
    logic           resp_parity;
    logic           resp_zero;
    logic           resp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, ser_in,
        input  req_ready, ser_out, resp_valid, resp_op, resp_result, resp_parity, resp_zero, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, ser_in,
        output req_ready, ser_out, resp_valid, resp_op, resp_result, resp_parity, resp_zero, resp_err
    );
endinterface

// File: rtl/alu_serial_host.sv
// alu_serial_host: frames parallel ALU requests onto the serial link and rebuilds the replies.
module alu_serial_host #(
    parameter int         N         = 2,
    parameter logic [1:0] FILLER_OP = 2'b10
) (
    input logic              Clock,
    input logic              Reset,
    alu_serial_host_if.slave bus
);
    localparam int           L      = 2 + 2*N;
    localparam int           SW     = $clog2(L);
    localparam logic [L-1:0] FILLER = {FILLER_OP, {(2*N){1'b0}}};

    logic [SW-1:0]  slot, tx_idx;
    logic [L-1:0]   tx_frame, pend, next_frame, rx_sh, rx_full;
    logic           pend_full, tx_real, prev_real, boundary, accept;
    logic [1:0]     prev_op;
    logic [2*N-1:0] rx_result;

    // rx_full includes the bit arriving on this edge, so the last slot is usable at the boundary
    always_comb begin
        boundary   = slot == SW'(L-1);
        accept     = bus.req_valid && !pend_full;
        next_frame = pend_full ? pend : FILLER;
        tx_idx     = SW'(L-2) - slot;
        rx_full    = {rx_sh[L-2:0], bus.ser_in};
        rx_result  = rx_full[2*N-1:0];
    end

    assign bus.req_ready = !pend_full;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            slot            <= '0;
            bus.ser_out     <= FILLER_OP[1];
            tx_frame        <= FILLER;
            tx_real         <= 1'b0;
            prev_real       <= 1'b0;
            prev_op         <= '0;
            pend_full       <= 1'b0;
            pend            <= '0;
            rx_sh           <= '0;
            bus.resp_valid  <= 1'b0;
            bus.resp_op     <= '0;
            bus.resp_result <= '0;
            bus.resp_parity <= 1'b0;
            bus.resp_zero   <= 1'b0;
            bus.resp_err    <= 1'b0;
        end else begin
            slot           <= boundary ? '0 : slot + SW'(1);
            rx_sh          <= rx_full;
            bus.resp_valid <= boundary && prev_real;
            if (boundary) begin
                tx_frame    <= next_frame;
                tx_real     <= pend_full;
                prev_real   <= tx_real;
                prev_op     <= tx_frame[L-1:L-2];
                bus.ser_out <= next_frame[L-1];
                if (prev_real) begin
                    bus.resp_op     <= prev_op;
                    bus.resp_result <= rx_result;
                    bus.resp_parity <= rx_full[L-1];
                    bus.resp_zero   <= rx_full[L-2];
                    bus.resp_err    <= (rx_full[L-1] != ^rx_result) || (rx_full[L-2] != (rx_result == '0));
                end
            end else begin
                bus.ser_out <= tx_frame[tx_idx];
            end
            if (boundary && pend_full) begin
                pend_full <= 1'b0;
            end else if (accept) begin
                pend_full <= 1'b1;
                pend      <= {bus.req_op, bus.req_a, bus.req_b};
            end
        end
    end
endmodule

// File: tb/tb_alu_serial_host.sv
// tb_alu_serial_host: directed bench with a behavioural bit-serial ALU on the far end of the link.
module tb_alu_serial_host;
    localparam int N = 2;
    localparam int L = 6;

    typedef struct {
        logic [1:0] op;
        logic [3:0] res;
        logic       par;
        logic       zer;
        logic       err;
        int         cyc;
    } resp_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   tb_slot = 0;
    bit   flip_en = 1'b0;
    resp_t rq[$];

    alu_serial_host_if #(.N(N)) bus();
    alu_serial_host #(.N(N)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        cyc     <= cyc + 1;
        tb_slot <= Reset ? 0 : (tb_slot == L-1 ? 0 : tb_slot + 1);
    end

    always @(negedge Clock)
        if (bus.resp_valid === 1'b1)
            rq.push_back('{bus.resp_op, bus.resp_result, bus.resp_parity, bus.resp_zero, bus.resp_err, cyc});

    // ALU model: falling-edge slots, reply of frame k computed from the frame received in k-1
    logic [L-1:0] a_in = '0;
    logic [L-1:0] a_reply = '0;
    int           a_slot = 0;
    always @(negedge Clock) begin
        logic [3:0] res;
        logic [1:0] a, b;
        if (Reset) begin
            a_slot     = 0;
            a_reply    = '0;
            bus.ser_in = 1'b0;
        end else begin
            bus.ser_in = a_reply[a_slot];
            a_in = {a_in[L-2:0], bus.ser_out};
            if (a_slot == L-1) begin
                a = a_in[3:2];
                b = a_in[1:0];
                case (a_in[5:4])
                    2'b10:   res = 4'(a) + 4'(b);
                    2'b01:   res = 4'(a) - 4'(b);
                    2'b11:   res = 4'(a) * 4'(b);
                    default: res = (b == 2'd0) ? 4'd0 : 4'(a / b);
                endcase
                a_reply = {res[0], res[1], res[2], res[3], res == 4'd0, ^res};
                if (flip_en && a_in == 6'b100100) a_reply[0] = ~a_reply[0];
            end
            a_slot = (a_slot == L-1) ? 0 : a_slot + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic to_slot(input int s);
        for (int n = 0; n < 20 && tb_slot != s; n++) step();
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b, output int acc);
        bit ok = 1'b0;
        bus.req_op = op;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (bus.req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        bus.req_valid = 1'b0;
        acc = cyc;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout req_ready got=%b exp=1", bus.req_ready);
        end
    endtask

    task automatic wait_resp(output resp_t r);
        for (int n = 0; n < 40 && rq.size() == 0; n++) step();
        checks++;
        if (rq.size() == 0) begin
            failures++;
            $display("FAIL resp_timeout got=none exp=resp_valid");
            r = '{2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 0};
        end else begin
            r = rq.pop_front();
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_op = 2'b00;
        bus.req_a = '0;
        bus.req_b = '0;
        Reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({bus.ser_out, bus.req_ready, bus.resp_valid} !== 3'b110) begin
            failures++;
            $display("FAIL reset_ctrl ser_out/ready/valid got=%b exp=110", {bus.ser_out, bus.req_ready, bus.resp_valid});
        end
        checks++;
        if ({bus.resp_op, bus.resp_result, bus.resp_parity, bus.resp_zero, bus.resp_err} !== 9'd0) begin
            failures++;
            $display("FAIL reset_resp fields got=%b exp=0", {bus.resp_op, bus.resp_result, bus.resp_parity, bus.resp_zero, bus.resp_err});
        end
        Reset = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3*L; i++) begin
            checks++;
            if ({bus.ser_out, bus.req_ready, bus.resp_valid} !== {i % L == 0, 2'b10}) begin
                failures++;
                $display("FAIL idle_slot%0d ser_out/ready/valid got=%b exp=%b", i, {bus.ser_out, bus.req_ready, bus.resp_valid}, {i % L == 0, 2'b10});
            end
            step();
        end
        checks++;
        if (rq.size() != 0) begin
            failures++;
            $display("FAIL idle_resp count got=%0d exp=0", rq.size());
        end
    endtask

    task automatic test_sum();
        int acc;
        resp_t r;
        logic [5:0] e = 6'b101110;
        to_slot(0);
        send(2'b10, 2'd3, 2'd2, acc);
        to_slot(0);
        for (int s = 0; s < L; s++) begin
            checks++;
            if (bus.ser_out !== e[5-s]) begin
                failures++;
                $display("FAIL sum_tx slot%0d got=%b exp=%b", s, bus.ser_out, e[5-s]);
            end
            step();
        end
        wait_resp(r);
        checks++;
        if (r.cyc - acc != 17) begin
            failures++;
            $display("FAIL sum_latency got=%0d exp=17", r.cyc - acc);
        end
        checks++;
        if ({r.op, r.res, r.par, r.zer, r.err} !== {2'b10, 4'b0101, 3'b000}) begin
            failures++;
            $display("FAIL sum_resp op/res/par/zero/err got=%b exp=%b", {r.op, r.res, r.par, r.zer, r.err}, {2'b10, 4'b0101, 3'b000});
        end
    endtask

    task automatic test_ops();
        logic [1:0] ops[3] = '{2'b01, 2'b11, 2'b10};
        logic [1:0] as[3]  = '{2'd1, 2'd3, 2'd0};
        logic [1:0] bs[3]  = '{2'd2, 2'd3, 2'd0};
        logic [8:0] ex[3]  = '{{2'b01, 4'b1111, 3'b000}, {2'b11, 4'b1001, 3'b000}, {2'b10, 4'b0000, 3'b010}};
        int acc;
        resp_t r;
        for (int i = 0; i < 3; i++) begin
            send(ops[i], as[i], bs[i], acc);
            wait_resp(r);
            checks++;
            if ({r.op, r.res, r.par, r.zer, r.err} !== ex[i]) begin
                failures++;
                $display("FAIL ops%0d op/res/par/zero/err got=%b exp=%b", i, {r.op, r.res, r.par, r.zer, r.err}, ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops[4] = '{2'b10, 2'b01, 2'b11, 2'b00};
        logic [1:0] as[4]  = '{2'd2, 2'd0, 2'd2, 2'd3};
        logic [1:0] bs[4]  = '{2'd1, 2'd1, 2'd2, 2'd1};
        logic [3:0] ex[4]  = '{4'b0011, 4'b1111, 4'b0100, 4'b0011};
        int acc[4];
        resp_t r[4];
        to_slot(0);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req_op = ops[i];
            bus.req_a = as[i];
            bus.req_b = bs[i];
            for (int n = 0; n < 20 && bus.req_ready !== 1'b1; n++) step();
            step();
            acc[i] = cyc;
            checks++;
            if (bus.req_ready !== 1'b0) begin
                failures++;
                $display("FAIL b2b_ready_full%0d got=%b exp=0", i, bus.req_ready);
            end
        end
        bus.req_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (acc[i] - acc[i-1] != L) begin
                failures++;
                $display("FAIL b2b_accept_gap%0d got=%0d exp=%0d", i, acc[i] - acc[i-1], L);
            end
        end
        for (int i = 0; i < 4; i++) wait_resp(r[i]);
        checks++;
        if (r[0].cyc - acc[0] != 17) begin
            failures++;
            $display("FAIL b2b_latency got=%0d exp=17", r[0].cyc - acc[0]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({r[i].op, r[i].res, r[i].err} !== {ops[i], ex[i], 1'b0}) begin
                failures++;
                $display("FAIL b2b_resp%0d op/res/err got=%b exp=%b", i, {r[i].op, r[i].res, r[i].err}, {ops[i], ex[i], 1'b0});
            end
            if (i > 0) begin
                checks++;
                if (r[i].cyc - r[i-1].cyc != L) begin
                    failures++;
                    $display("FAIL b2b_resp_gap%0d got=%0d exp=%0d", i, r[i].cyc - r[i-1].cyc, L);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        resp_t r;
        to_slot(2);
        send(2'b11, 2'd2, 2'd3, acc);
        to_slot(0);
        send(2'b10, 2'd1, 2'd1, acc);
        to_slot(3);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if (dut.slot !== 3'd0) begin
            failures++;
            $display("FAIL rst_mid_slot got=%0d exp=0", dut.slot);
        end
        checks++;
        if ({bus.ser_out, bus.req_ready, bus.resp_valid, bus.resp_result} !== 7'b1100000) begin
            failures++;
            $display("FAIL rst_mid_state ser_out/ready/valid/result got=%b exp=1100000", {bus.ser_out, bus.req_ready, bus.resp_valid, bus.resp_result});
        end
        repeat (4*L) step();
        checks++;
        if (rq.size() != 0) begin
            failures++;
            $display("FAIL rst_mid_discard resp count got=%0d exp=0", rq.size());
        end
        send(2'b10, 2'd1, 2'd2, acc);
        wait_resp(r);
        checks++;
        if ({r.op, r.res, r.par, r.zer, r.err} !== {2'b10, 4'b0011, 3'b000}) begin
            failures++;
            $display("FAIL rst_mid_after op/res/par/zero/err got=%b exp=%b", {r.op, r.res, r.par, r.zer, r.err}, {2'b10, 4'b0011, 3'b000});
        end
    endtask

    task automatic test_parity_flip();
        int acc;
        resp_t r;
        flip_en = 1'b1;
        send(2'b10, 2'd1, 2'd0, acc);
        wait_resp(r);
        flip_en = 1'b0;
        checks++;
        if ({r.op, r.res, r.par, r.zer, r.err} !== {2'b10, 4'b0001, 3'b001}) begin
            failures++;
            $display("FAIL flip_resp op/res/par/zero/err got=%b exp=%b", {r.op, r.res, r.par, r.zer, r.err}, {2'b10, 4'b0001, 3'b001});
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_sum();
        test_ops();
        test_back_to_back();
        test_reset_mid();
        test_parity_flip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
